// File: rtl/vid_fetch_sched.sv
// Pixel-fetch scheduler: walks the frame buffer line by line, issues one burst read
// at a time on the shared bus and pushes returned pixels into the colour FIFOs.
// Bus handshake: reqout=2'b11 is held until ackin; the next cycle is the single
// address phase; beats are accepted only on cycles where cmdin==3'b011.
module vid_fetch_sched #(
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_start,
  input  logic [31:0] base_address,
  input  logic [31:0] lineinc,
  input  logic [12:0] hsize,
  input  logic [12:0] vsize,
  input  logic [4:0]  fifo_level,
  input  logic        ackin,
  input  logic [2:0]  cmdin,
  input  logic [31:0] addrdatain,
  output logic [1:0]  reqout,
  output logic [2:0]  cmdout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout,
  output logic        fifo_wr,
  output logic [23:0] fifo_rgb,
  output logic        frame_done,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_FRAME = 3'd1,
    S_CHECK      = 3'd2,
    S_ARB        = 3'd3,
    S_ADDR       = 3'd4,
    S_DATA       = 3'd5
  } state_t;

  localparam int             BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [1:0]     LEN_CODE  = 2'($clog2(BURST_LEN));
  localparam logic [4:0]     LEVEL_MAX = 5'(FIFO_DEPTH - BURST_LEN);
  localparam logic [2:0]     CMD_RDREQ = 3'b010;
  localparam logic [2:0]     CMD_BEAT  = 3'b011;

  state_t        state;
  logic          pending;
  logic [31:0]   addr;
  logic [31:0]   line_addr;
  logic [13:0]   pix_cnt;
  logic [12:0]   line_cnt;
  logic [BW-1:0] beat_cnt;

  logic [13:0]   pix_next;
  logic [12:0]   line_next;
  logic [31:0]   line_addr_next;
  logic          beat_ok;
  logic          last_beat;
  logic          line_end;
  logic          unused_hi;

  assign pix_next       = pix_cnt + 14'd1;
  assign line_next      = line_cnt + 13'd1;
  assign line_addr_next = line_addr + lineinc;
  assign beat_ok        = (cmdin == CMD_BEAT);
  assign last_beat      = (beat_cnt == LAST_BEAT);
  // pix_cnt is one bit wider than hsize so tail beats past hsize cannot wrap it
  assign line_end       = (pix_next >= {1'b0, hsize});
  assign unused_hi      = ^addrdatain[31:24];
  assign state_dbg      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pending     <= 1'b0;
      addr        <= 32'd0;
      line_addr   <= 32'd0;
      pix_cnt     <= 14'd0;
      line_cnt    <= 13'd0;
      beat_cnt    <= '0;
      reqout      <= 2'b00;
      cmdout      <= 3'b000;
      lenout      <= 2'b00;
      addrdataout <= 32'd0;
      fifo_wr     <= 1'b0;
      fifo_rgb    <= 24'd0;
      frame_done  <= 1'b0;
    end else begin
      fifo_wr    <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start && (state != S_WAIT_FRAME))
        pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (enable)
            state <= S_WAIT_FRAME;
        end

        S_WAIT_FRAME: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (frame_start || pending) begin
            pending   <= 1'b0;
            addr      <= base_address;
            line_addr <= base_address;
            pix_cnt   <= 14'd0;
            line_cnt  <= 13'd0;
            beat_cnt  <= '0;
            state     <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (pending || (line_cnt == vsize)) begin
            state <= S_WAIT_FRAME;
          end else if (fifo_level <= LEVEL_MAX) begin
            reqout <= 2'b11;
            state  <= S_ARB;
          end
        end

        S_ARB: begin
          if (ackin) begin
            reqout      <= 2'b00;
            cmdout      <= CMD_RDREQ;
            lenout      <= LEN_CODE;
            addrdataout <= addr;
            state       <= S_ADDR;
          end
        end

        S_ADDR: begin
          cmdout      <= 3'b000;
          lenout      <= 2'b00;
          addrdataout <= 32'd0;
          state       <= S_DATA;
        end

        S_DATA: begin
          if (beat_ok) begin
            fifo_wr  <= (pix_cnt < {1'b0, hsize});
            fifo_rgb <= addrdatain[23:0];
            if (last_beat) begin
              beat_cnt <= '0;
              // enable is only honoured here so a granted burst always completes
              state    <= enable ? S_CHECK : S_IDLE;
              if (line_end) begin
                line_addr <= line_addr_next;
                addr      <= line_addr_next;
                pix_cnt   <= 14'd0;
                line_cnt  <= line_next;
                if (line_next == vsize)
                  frame_done <= 1'b1;
              end else begin
                addr    <= addr + 32'd4;
                pix_cnt <= pix_next;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              pix_cnt  <= pix_next;
              addr     <= addr + 32'd4;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vid_fetch_sched.sv
// Bench for vid_fetch_sched: a cycle-level bus responder feeds bursts, and a
// scoreboard checks burst addresses, pushed pixels and frame_done pulses.
module tb_vid_fetch_sched;
  localparam int BL = 4;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd5;

  logic        clk, reset, enable, frame_start;
  logic [31:0] base_address, lineinc;
  logic [12:0] hsize, vsize;
  logic [4:0]  fifo_level;
  logic        ackin;
  logic [2:0]  cmdin;
  logic [31:0] addrdatain;
  logic [1:0]  reqout;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;
  logic        fifo_wr;
  logic [23:0] fifo_rgb;
  logic        frame_done;
  logic [2:0]  state_dbg;

  vid_fetch_sched #(.BURST_LEN(BL), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .base_address(base_address), .lineinc(lineinc), .hsize(hsize), .vsize(vsize),
    .fifo_level(fifo_level), .ackin(ackin), .cmdin(cmdin), .addrdatain(addrdatain),
    .reqout(reqout), .cmdout(cmdout), .lenout(lenout), .addrdataout(addrdataout),
    .fifo_wr(fifo_wr), .fifo_rgb(fifo_rgb), .frame_done(frame_done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [23:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          exp_n_q[$];
  int checks = 0, failures = 0;
  int bursts = 0, pushes = 0, fd_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // expected bursts of one full frame
  task automatic push_frame(input logic [31:0] base, input logic [31:0] inc,
                            input int h, input int v);
    for (int l = 0; l < v; l++)
      for (int p = 0; p < h; p += BL) begin
        exp_addr_q.push_back(base + 32'(l) * inc + 32'(p) * 32'd4);
        exp_n_q.push_back((h - p) < BL ? (h - p) : BL);
      end
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int lim);
    int n = 0;
    while (state_dbg !== st && n < lim) begin
      tick(1);
      n++;
    end
    check(tag, state_dbg, st);
  endtask

  task automatic wait_fd(input string tag, input int start, input int lim);
    int n = 0;
    while (fd_cnt <= start && n < lim) begin
      tick(1);
      n++;
    end
    check(tag, fd_cnt - start, 1);
  endtask

  // bus responder driver: ack two cycles after the bid, then BL beats with random stalls
  initial begin
    int bst = 0, dly = 0, beat = 0, npush = 0;
    logic [31:0] d;
    ackin = 1'b0;
    cmdin = 3'b000;
    addrdatain = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        bst = 0;
        ackin = 1'b0;
        cmdin = 3'b000;
        addrdatain = 32'd0;
        exp_q.delete();
        exp_addr_q.delete();
        exp_n_q.delete();
      end else begin
        case (bst)
          0: if (reqout == 2'b11) begin
               dly = 0;
               bst = 1;
             end
          1: begin
               dly++;
               if (dly == 2) begin
                 ackin = 1'b1;
                 bst = 2;
               end
             end
          2: begin
               ackin = 1'b0;
               bursts++;
               check("addr_cmd", cmdout, 3'b010);
               check("addr_len", lenout, 2'd2);
               check("addr_req", reqout, 2'b00);
               check("burst_pending", exp_addr_q.size() != 0, 1);
               npush = 0;
               if (exp_addr_q.size() != 0) begin
                 check("burst_addr", addrdataout, exp_addr_q.pop_front());
                 npush = exp_n_q.pop_front();
               end
               beat = 0;
               bst = 3;
             end
          3: begin
               if ($urandom_range(0, 2) == 0) begin
                 cmdin = 3'($urandom_range(0, 2));
                 addrdatain = $urandom;
               end else begin
                 d = $urandom;
                 cmdin = 3'b011;
                 addrdatain = d;
                 if (beat < npush) exp_q.push_back(d[23:0]);
                 beat++;
                 if (beat == BL) bst = 4;
               end
             end
          default: begin
               cmdin = 3'b000;
               addrdatain = 32'd0;
               bst = 0;
             end
        endcase
      end
    end
  end

  // output monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (fifo_wr) begin
          pushes++;
          check("push_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("push_rgb", fifo_rgb, exp_q.pop_front());
        end
        if (frame_done) fd_cnt++;
      end
    end
  end

  initial begin
    int b0, p0, f0;
    reset = 1'b1;
    enable = 1'b0;
    frame_start = 1'b0;
    base_address = 32'd0;
    lineinc = 32'd0;
    hsize = 13'd1;
    vsize = 13'd1;
    fifo_level = 5'd0;
    tick(3);
    check("rst_reqout", reqout, 2'b00);
    check("rst_cmdout", cmdout, 3'b000);
    check("rst_lenout", lenout, 2'b00);
    check("rst_addrdata", addrdataout, 32'd0);
    check("rst_fifo_wr", fifo_wr, 1'b0);
    check("rst_fifo_rgb", fifo_rgb, 24'd0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b0;
    tick(2);

    // T1: two lines of two bursts each
    base_address = 32'h1000; lineinc = 32'h40; hsize = 13'd8; vsize = 13'd2;
    push_frame(32'h1000, 32'h40, 8, 2);
    enable = 1'b1;
    tick(1);
    b0 = bursts; p0 = pushes; f0 = fd_cnt;
    pulse_fs();
    wait_fd("t1_frame_done", f0, 400);
    tick(4);
    check("t1_bursts", bursts - b0, 4);
    check("t1_pushes", pushes - p0, 16);
    check("t1_frame_done_once", fd_cnt - f0, 1);
    check("t1_addr_q_empty", exp_addr_q.size(), 0);
    check("t1_state", state_dbg, ST_WAIT);

    // T2: occupancy throttle at the FIFO_DEPTH-BURST_LEN boundary
    base_address = 32'h1800; hsize = 13'd4; vsize = 13'd1; fifo_level = 5'd13;
    push_frame(32'h1800, 32'h40, 4, 1);
    b0 = bursts; p0 = pushes; f0 = fd_cnt;
    pulse_fs();
    tick(10);
    check("t2_no_bid", reqout, 2'b00);
    check("t2_in_check", state_dbg, ST_CHECK);
    check("t2_no_burst", bursts - b0, 0);
    fifo_level = 5'd12;
    tick(1);
    check("t2_bid", reqout, 2'b11);
    fifo_level = 5'd0;
    wait_fd("t2_frame_done", f0, 200);
    tick(4);
    check("t2_pushes", pushes - p0, 4);

    // T3: hsize not a multiple of the burst length
    base_address = 32'h2000; lineinc = 32'h100; hsize = 13'd6; vsize = 13'd2;
    push_frame(32'h2000, 32'h100, 6, 2);
    b0 = bursts; p0 = pushes; f0 = fd_cnt;
    pulse_fs();
    wait_fd("t3_frame_done", f0, 400);
    tick(4);
    check("t3_bursts", bursts - b0, 4);
    check("t3_pushes", pushes - p0, 12);

    // T4: frame_start during the first burst restarts from base after it completes
    base_address = 32'h3000; lineinc = 32'h80; hsize = 13'd8; vsize = 13'd2;
    exp_addr_q.push_back(32'h3000);
    exp_n_q.push_back(4);
    push_frame(32'h3000, 32'h80, 8, 2);
    b0 = bursts; p0 = pushes; f0 = fd_cnt;
    pulse_fs();
    wait_state("t4_in_data", ST_DATA, 50);
    pulse_fs();
    wait_fd("t4_frame_done", f0, 500);
    tick(4);
    check("t4_bursts", bursts - b0, 5);
    check("t4_pushes", pushes - p0, 20);
    check("t4_frame_done_once", fd_cnt - f0, 1);

    // T5: enable drops mid-burst
    base_address = 32'h4000;
    exp_addr_q.push_back(32'h4000);
    exp_n_q.push_back(4);
    b0 = bursts; p0 = pushes; f0 = fd_cnt;
    pulse_fs();
    wait_state("t5_in_data", ST_DATA, 50);
    enable = 1'b0;
    wait_state("t5_idle", ST_IDLE, 50);
    tick(3);
    check("t5_reqout", reqout, 2'b00);
    check("t5_cmdout", cmdout, 3'b000);
    check("t5_bursts", bursts - b0, 1);
    check("t5_pushes", pushes - p0, 4);
    check("t5_no_frame_done", fd_cnt - f0, 0);
    check("t5_state_hold", state_dbg, ST_IDLE);

    // T6: asynchronous reset mid-burst, then a clean restart from base
    base_address = 32'h5000; hsize = 13'd8; vsize = 13'd1;
    enable = 1'b1;
    push_frame(32'h5000, 32'h80, 8, 1);
    tick(1);
    pulse_fs();
    wait_state("t6_in_data", ST_DATA, 50);
    tick(2);
    reset = 1'b1;
    #1;
    check("t6_rst_reqout", reqout, 2'b00);
    check("t6_rst_cmdout", cmdout, 3'b000);
    check("t6_rst_fifo_wr", fifo_wr, 1'b0);
    check("t6_rst_addrdata", addrdataout, 32'd0);
    check("t6_rst_state", state_dbg, ST_IDLE);
    tick(3);
    reset = 1'b0;
    tick(1);
    push_frame(32'h5000, 32'h80, 8, 1);
    b0 = bursts; p0 = pushes; f0 = fd_cnt;
    tick(1);
    pulse_fs();
    wait_fd("t6_frame_done", f0, 300);
    tick(4);
    check("t6_bursts", bursts - b0, 2);
    check("t6_pushes", pushes - p0, 8);
    check("t6_rgb_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
